// File: rtl/line_mem_responder.sv
// Shared 128-bit line memory serving a data port and a fetch port with fixed-latency, one-at-a-time access.
// Optional macro LINE_MEM_ADDR_CHECK_EN enables out-of-range detection and the sticky addr_err flag.
module line_mem_responder #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [11:0]  mem_address,
    input  logic [127:0] mem_wdata,
    input  logic [15:0]  mem_sel,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    input  logic         ifetch_read,
    input  logic [11:0]  ifetch_address,
    output logic [127:0] ifetch_rdata,
    output logic         ifetch_resp,
    output logic         addr_err
);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

    state_t      state;
    logic [3:0]  count;
    logic        last_fetch;
    logic [11:0] lat_addr;
    logic [127:0] lat_wdata;
    logic [15:0] lat_sel;
    logic        lat_write;

    logic [127:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic        data_req;
    logic        grant_data;
    logic        grant_fetch;
    logic        fire;
    logic        fire_data;
    logic [11:0] f_addr;
    logic [127:0] f_wdata;
    logic [15:0] f_sel;
    logic        f_write;
    logic        oor;
    logic [DEPTH_LOG2-1:0] idx;

    always_comb begin
        data_req    = mem_read | mem_write;
        grant_data  = (state == IDLE) && data_req && (!ifetch_read || last_fetch);
        grant_fetch = (state == IDLE) && ifetch_read && (!data_req || !last_fetch);
    end

    // The access fires on the edge that brings the counter to zero, so the
    // resp/rdata registers become visible exactly LATENCY cycles after grant.
    // With LATENCY=1 that edge is the grant edge itself, using live inputs.
    always_comb begin
        fire      = 1'b0;
        fire_data = 1'b0;
        f_addr    = lat_addr;
        f_wdata   = lat_wdata;
        f_sel     = lat_sel;
        f_write   = lat_write;
        if (LATENCY == 1) begin
            if (grant_data || grant_fetch) begin
                fire      = 1'b1;
                fire_data = grant_data;
                f_addr    = grant_data ? mem_address : ifetch_address;
                f_wdata   = mem_wdata;
                f_sel     = mem_sel;
                f_write   = grant_data && mem_write;
            end
        end else if (state != IDLE && count == 4'd1) begin
            fire      = 1'b1;
            fire_data = (state == D_BUSY);
        end
    end

    assign idx = f_addr[DEPTH_LOG2-1:0];

`ifdef LINE_MEM_ADDR_CHECK_EN
    assign oor = (f_addr >> DEPTH_LOG2) != '0;
`else
    logic unused_high_bits;
    assign unused_high_bits = |(f_addr >> DEPTH_LOG2);
    assign oor = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && fire && f_write && !oor) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (f_sel[i]) mem[idx][8*i +: 8] <= f_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            last_fetch   <= 1'b1;
            mem_resp     <= 1'b0;
            ifetch_resp  <= 1'b0;
            mem_rdata    <= '0;
            ifetch_rdata <= '0;
            addr_err     <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_sel      <= '0;
            lat_write    <= 1'b0;
        end else begin
            mem_resp    <= fire && fire_data;
            ifetch_resp <= fire && !fire_data;
            if (fire) begin
                if (oor) addr_err <= 1'b1;
                if (!f_write) begin
                    if (fire_data) mem_rdata <= oor ? '0 : mem[idx];
                    else ifetch_rdata <= oor ? '0 : mem[idx];
                end
            end
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state      <= D_BUSY;
                        count      <= 4'(LATENCY - 1);
                        last_fetch <= 1'b0;
                        lat_addr   <= mem_address;
                        lat_wdata  <= mem_wdata;
                        lat_sel    <= mem_sel;
                        lat_write  <= mem_write;
                    end else if (grant_fetch) begin
                        state      <= I_BUSY;
                        count      <= 4'(LATENCY - 1);
                        last_fetch <= 1'b1;
                        lat_addr   <= ifetch_address;
                        lat_write  <= 1'b0;
                    end
                end
                default: begin
                    if (count == '0) state <= IDLE;
                    else count <= count - 4'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed, table-driven bench for line_mem_responder (LATENCY=3, DEPTH_LOG2=6).
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [11:0]  mem_address = '0;
    logic [127:0] mem_wdata = '0;
    logic [15:0]  mem_sel = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         ifetch_read = 1'b0;
    logic [11:0]  ifetch_address = '0;
    logic [127:0] ifetch_rdata;
    logic         ifetch_resp;
    logic         addr_err;

    int checks = 0;
    int errors = 0;

`ifdef LINE_MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [127:0] LA  = 128'h7766_5544_3322_1100_00FF_EEDD_CCBB_AA99;
    localparam logic [127:0] LB  = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1234_5678;
    localparam logic [127:0] LC  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LC2 = 128'hFF23_4567_89AB_CDEF_FEDC_BA98_7654_32FF;
    localparam logic [127:0] L1  = {16{8'h11}};
    localparam logic [127:0] L2  = {16{8'h22}};
    localparam logic [127:0] L3  = {16{8'h33}};
    localparam logic [127:0] M1  = 128'h1111_1111_1111_1111_1111_1111_1111_2222;
    localparam logic [127:0] LAA = {16{8'hAA}};
    localparam logic [127:0] L55 = {16{8'h55}};
    localparam logic [127:0] LD  = 128'hDDDD_0000_DDDD_0000_1234_4321_ABCD_DCBA;

    line_mem_responder #(.LATENCY(3), .DEPTH_LOG2(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
        .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [11:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  sel;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one data-port access from an IDLE-aligned point; returns cycles to mem_resp (-1 on timeout).
    task automatic txn(input logic rd, input logic wr, input logic [11:0] a,
                       input logic [127:0] wd, input logic [15:0] s, output int lat);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_sel = s;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (mem_resp) lat = k;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        vecs[0]  = '{1'b0, 1'b1, 12'h005, LA,   16'hFFFF, 128'h0};
        vecs[1]  = '{1'b1, 1'b0, 12'h005, 128'h0, 16'h0,  LA};
        vecs[2]  = '{1'b0, 1'b1, 12'h00A, L1,   16'hFFFF, LA};
        vecs[3]  = '{1'b0, 1'b1, 12'h00A, L2,   16'h0003, LA};
        vecs[4]  = '{1'b1, 1'b0, 12'h00A, 128'h0, 16'h0,  M1};
        vecs[5]  = '{1'b0, 1'b1, 12'h00A, L3,   16'h0000, M1};
        vecs[6]  = '{1'b1, 1'b0, 12'h00A, 128'h0, 16'h0,  M1};
        vecs[7]  = '{1'b0, 1'b1, 12'h000, LB,   16'hFFFF, M1};
        vecs[8]  = '{1'b1, 1'b0, 12'h040, 128'h0, 16'h0,  CHK ? 128'h0 : LB};
        vecs[9]  = '{1'b1, 1'b1, 12'h00C, LC,   16'hFFFF, CHK ? 128'h0 : LB};
        vecs[10] = '{1'b1, 1'b0, 12'h00C, 128'h0, 16'h0,  LC};
        vecs[11] = '{1'b0, 1'b1, 12'h00C, {16{8'hFF}}, 16'h8001, LC};
        vecs[12] = '{1'b1, 1'b0, 12'h00C, 128'h0, 16'h0,  LC2};

        // Asynchronous reset: outputs must clear without a clock edge
        #1 rst_n = 1'b0;
        #2;
        check("reset_mem_resp", {127'h0, mem_resp}, 128'h0);
        check("reset_ifetch_resp", {127'h0, ifetch_resp}, 128'h0);
        check("reset_mem_rdata", mem_rdata, 128'h0);
        check("reset_ifetch_rdata", ifetch_rdata, 128'h0);
        check("reset_addr_err", {127'h0, addr_err}, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sel, lat);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd3);
            check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
        end
        check("addr_err_after_table", {127'h0, addr_err}, {127'h0, CHK});

        // Arbitration with fetch held high: data wins first tie, then alternation
        do_reset();
        mem_read = 1'b1; mem_address = 12'h005;
        ifetch_read = 1'b1; ifetch_address = 12'h00A;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check($sformatf("arb_mem_resp_c%0d", k), {127'h0, mem_resp},
                  {127'h0, (k == 3 || k == 11)});
            check($sformatf("arb_ifetch_resp_c%0d", k), {127'h0, ifetch_resp},
                  {127'h0, (k == 7 || k == 15)});
            if (k == 3) check("arb_mem_rdata", mem_rdata, LA);
            if (k == 7) check("arb_ifetch_rdata", ifetch_rdata, M1);
        end
        mem_read = 1'b0; ifetch_read = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Request dropped after grant, other inputs changed while busy
        mem_write = 1'b1; mem_address = 12'h007; mem_wdata = LD; mem_sel = 16'hFFFF;
        @(posedge clk); #1;
        mem_write = 1'b0; mem_address = 12'h005; mem_wdata = L55; mem_sel = 16'h0000;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("drop_mem_resp_c%0d", k), {127'h0, mem_resp}, {127'h0, (k == 3)});
        end
        txn(1'b1, 1'b0, 12'h007, 128'h0, 16'h0, lat);
        check("drop_read_latency", 128'(lat), 128'd3);
        check("drop_read_rdata", mem_rdata, LD);

        // Reset in the middle of a write aborts it
        txn(1'b0, 1'b1, 12'h003, LAA, 16'hFFFF, lat);
        txn(1'b1, 1'b0, 12'h005, 128'h0, 16'h0, lat);
        check("pre_abort_rdata", mem_rdata, LA);
        mem_write = 1'b1; mem_address = 12'h003; mem_wdata = L55; mem_sel = 16'hFFFF;
        @(posedge clk); #1;
        rst_n = 1'b0; mem_write = 1'b0;
        #1;
        check("abort_mem_rdata", mem_rdata, 128'h0);
        check("abort_ifetch_rdata", ifetch_rdata, 128'h0);
        check("abort_mem_resp", {127'h0, mem_resp}, 128'h0);
        check("abort_addr_err", {127'h0, addr_err}, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort_no_resp_c%0d", k), {127'h0, mem_resp}, 128'h0);
        end
        txn(1'b1, 1'b0, 12'h003, 128'h0, 16'h0, lat);
        check("abort_read_latency", 128'(lat), 128'd3);
        check("abort_read_rdata", mem_rdata, LAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
